// File: rtl/uart_tx_fifo_if.sv
// Producer-side handshake and line/status bundle for uart_tx_fifo.
// The producer drives the write strobe and word; the transmitter drives the rest.
interface uart_tx_fifo_if #(
  parameter int DATA_BITS  = 8,
  parameter int FIFO_DEPTH = 4
);
  logic                          in_Tx_DV;
  logic [DATA_BITS-1:0]          in_Tx_Byte;
  logic                          out_Tx_Ready;
  logic [$clog2(FIFO_DEPTH):0]   out_Fifo_Count;
  logic                          out_Tx_Active;
  logic                          out_Tx_Serial;
  logic                          out_Tx_Done;

  modport master (
    output in_Tx_DV,
    output in_Tx_Byte,
    input  out_Tx_Ready,
    input  out_Fifo_Count,
    input  out_Tx_Active,
    input  out_Tx_Serial,
    input  out_Tx_Done
  );

  modport slave (
    input  in_Tx_DV,
    input  in_Tx_Byte,
    output out_Tx_Ready,
    output out_Fifo_Count,
    output out_Tx_Active,
    output out_Tx_Serial,
    output out_Tx_Done
  );
endinterface

// File: rtl/uart_tx_fifo.sv
// Configurable UART transmitter (5-9 data bits, optional parity, 1-2 stop bits)
// fed by a small FIFO so queued frames leave back-to-back with no idle gap.
module uart_tx_fifo #(
  parameter int CLKS_PER_BIT = 87,
  parameter int DATA_BITS    = 8,
  parameter int PARITY_EN    = 0,
  parameter int PARITY_ODD   = 0,
  parameter int STOP_BITS    = 1,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic          in_Clock,
  input  logic          in_Reset_n,
  uart_tx_fifo_if.slave tx_if
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int BW = $clog2(DATA_BITS);

  localparam logic [CW-1:0] LAST_CLK  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] CLK_ONE   = CW'(1);
  localparam logic [BW-1:0] LAST_BIT  = BW'(DATA_BITS - 1);
  localparam logic [BW-1:0] BIT_ONE   = BW'(1);
  localparam logic [AW:0]   FULL_CNT  = (AW+1)'(FIFO_DEPTH);
  localparam logic [AW:0]   CNT_ONE   = (AW+1)'(1);
  localparam logic [AW-1:0] PTR_ONE   = AW'(1);
  localparam logic          LAST_STOP = (STOP_BITS == 2) ? 1'b1 : 1'b0;
  localparam logic          ODD_BIT   = (PARITY_ODD != 0) ? 1'b1 : 1'b0;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } state_t;

  function automatic logic calc_parity(input logic [DATA_BITS-1:0] data);
    return (^data) ^ ODD_BIT;
  endfunction

  logic [DATA_BITS-1:0] r_mem [FIFO_DEPTH];
  logic [AW-1:0]        r_wr_ptr;
  logic [AW-1:0]        r_rd_ptr;
  logic [AW:0]          r_count;
  logic                 r_ready;

  state_t               r_state;
  logic [CW-1:0]        r_clk_cnt;
  logic [BW-1:0]        r_bit_idx;
  logic                 r_stop_idx;
  logic [DATA_BITS-1:0] r_shift;
  logic                 r_parity;
  logic                 r_serial;
  logic                 r_active;
  logic                 r_done;

  logic                 w_push;
  logic                 w_pop;
  logic                 w_have_data;
  logic                 w_bit_end;
  logic                 w_stop_end;
  logic [AW:0]          w_count_nxt;
  logic [DATA_BITS-1:0] w_head;

  // FIFO handshake decode and next-count calculation
  always_comb begin
    w_have_data = (r_count != {(AW+1){1'b0}});
    w_push      = tx_if.in_Tx_DV && r_ready;
    w_bit_end   = (r_clk_cnt == LAST_CLK);
    w_stop_end  = (r_state == S_STOP) && w_bit_end && (r_stop_idx == LAST_STOP);
    w_pop       = w_have_data && ((r_state == S_IDLE) || w_stop_end);
    w_head      = r_mem[r_rd_ptr];
    case ({w_push, w_pop})
      2'b10:   w_count_nxt = r_count + CNT_ONE;
      2'b01:   w_count_nxt = r_count - CNT_ONE;
      default: w_count_nxt = r_count;
    endcase
  end

  // FIFO storage; contents need no reset because the count gates every read
  always_ff @(posedge in_Clock) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= tx_if.in_Tx_Byte;
    end
  end

  // FIFO pointers, occupancy and registered ready
  always_ff @(posedge in_Clock or negedge in_Reset_n) begin
    if (!in_Reset_n) begin
      r_wr_ptr <= {AW{1'b0}};
      r_rd_ptr <= {AW{1'b0}};
      r_count  <= {(AW+1){1'b0}};
      r_ready  <= 1'b1;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + PTR_ONE;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_ONE;
      end
      r_count <= w_count_nxt;
      r_ready <= (w_count_nxt != FULL_CNT);
    end
  end

  // Frame sequencer; a pop (from IDLE or the end of STOP) always starts a new frame
  always_ff @(posedge in_Clock or negedge in_Reset_n) begin
    if (!in_Reset_n) begin
      r_state    <= S_IDLE;
      r_clk_cnt  <= {CW{1'b0}};
      r_bit_idx  <= {BW{1'b0}};
      r_stop_idx <= 1'b0;
      r_shift    <= {DATA_BITS{1'b0}};
      r_parity   <= 1'b0;
      r_serial   <= 1'b1;
      r_active   <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_done <= w_stop_end;
      if (w_pop) begin
        r_state    <= S_START;
        r_clk_cnt  <= {CW{1'b0}};
        r_bit_idx  <= {BW{1'b0}};
        r_stop_idx <= 1'b0;
        r_shift    <= w_head;
        r_parity   <= calc_parity(w_head);
        r_serial   <= 1'b0;
        r_active   <= 1'b1;
      end else begin
        case (r_state)
          S_IDLE: begin
            r_clk_cnt <= {CW{1'b0}};
            r_serial  <= 1'b1;
            r_active  <= 1'b0;
          end
          S_START: begin
            if (w_bit_end) begin
              r_clk_cnt <= {CW{1'b0}};
              r_serial  <= r_shift[0];
              r_state   <= S_DATA;
            end else begin
              r_clk_cnt <= r_clk_cnt + CLK_ONE;
            end
          end
          S_DATA: begin
            if (w_bit_end) begin
              r_clk_cnt <= {CW{1'b0}};
              if (r_bit_idx == LAST_BIT) begin
                if (PARITY_EN != 0) begin
                  r_serial <= r_parity;
                  r_state  <= S_PARITY;
                end else begin
                  r_serial <= 1'b1;
                  r_state  <= S_STOP;
                end
              end else begin
                r_bit_idx <= r_bit_idx + BIT_ONE;
                r_shift   <= {1'b0, r_shift[DATA_BITS-1:1]};
                r_serial  <= r_shift[1];
              end
            end else begin
              r_clk_cnt <= r_clk_cnt + CLK_ONE;
            end
          end
          S_PARITY: begin
            if (w_bit_end) begin
              r_clk_cnt <= {CW{1'b0}};
              r_serial  <= 1'b1;
              r_state   <= S_STOP;
            end else begin
              r_clk_cnt <= r_clk_cnt + CLK_ONE;
            end
          end
          S_STOP: begin
            if (w_bit_end) begin
              r_clk_cnt <= {CW{1'b0}};
              if (r_stop_idx == LAST_STOP) begin
                r_state  <= S_IDLE;
                r_serial <= 1'b1;
                r_active <= 1'b0;
              end else begin
                r_stop_idx <= 1'b1;
              end
            end else begin
              r_clk_cnt <= r_clk_cnt + CLK_ONE;
            end
          end
          default: begin
            r_state   <= S_IDLE;
            r_clk_cnt <= {CW{1'b0}};
            r_serial  <= 1'b1;
            r_active  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign tx_if.out_Tx_Ready   = r_ready;
  assign tx_if.out_Fifo_Count = r_count;
  assign tx_if.out_Tx_Active  = r_active;
  assign tx_if.out_Tx_Serial  = r_serial;
  assign tx_if.out_Tx_Done    = r_done;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Scoreboard bench for uart_tx_fifo: four instances cover 8N1, even/odd parity
// and 7-bit/2-stop framing; a line-decoding monitor per instance checks frames.
module tb_uart_tx_fifo;
  localparam int CPB = 4;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  uart_tx_fifo_if #(.DATA_BITS(8), .FIFO_DEPTH(4)) ifa ();
  uart_tx_fifo_if #(.DATA_BITS(8), .FIFO_DEPTH(4)) ifb ();
  uart_tx_fifo_if #(.DATA_BITS(8), .FIFO_DEPTH(4)) ifc ();
  uart_tx_fifo_if #(.DATA_BITS(7), .FIFO_DEPTH(4)) ifd ();

  uart_tx_fifo #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY_EN(0), .PARITY_ODD(0),
                 .STOP_BITS(1), .FIFO_DEPTH(4))
    u_a (.in_Clock(clk), .in_Reset_n(rst_n), .tx_if(ifa));
  uart_tx_fifo #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY_EN(1), .PARITY_ODD(0),
                 .STOP_BITS(1), .FIFO_DEPTH(4))
    u_b (.in_Clock(clk), .in_Reset_n(rst_n), .tx_if(ifb));
  uart_tx_fifo #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY_EN(1), .PARITY_ODD(1),
                 .STOP_BITS(1), .FIFO_DEPTH(4))
    u_c (.in_Clock(clk), .in_Reset_n(rst_n), .tx_if(ifc));
  uart_tx_fifo #(.CLKS_PER_BIT(CPB), .DATA_BITS(7), .PARITY_EN(0), .PARITY_ODD(0),
                 .STOP_BITS(2), .FIFO_DEPTH(4))
    u_d (.in_Clock(clk), .in_Reset_n(rst_n), .tx_if(ifd));

  logic [3:0] ser, act, dne;
  assign ser = {ifd.out_Tx_Serial, ifc.out_Tx_Serial, ifb.out_Tx_Serial, ifa.out_Tx_Serial};
  assign act = {ifd.out_Tx_Active, ifc.out_Tx_Active, ifb.out_Tx_Active, ifa.out_Tx_Active};
  assign dne = {ifd.out_Tx_Done, ifc.out_Tx_Done, ifb.out_Tx_Done, ifa.out_Tx_Done};

  int n_checks = 0;
  int n_fail   = 0;
  int done_cnt [4] = '{0, 0, 0, 0};

  // Expected frames, line order packed LSB first: bit0 = start bit.
  logic [15:0] q0[$];
  logic [15:0] q1[$];
  logic [15:0] q2[$];
  logic [15:0] q3[$];

  task automatic check_eq(input string name, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic sb_push(input int d, input logic [15:0] v);
    case (d)
      0: q0.push_back(v);
      1: q1.push_back(v);
      2: q2.push_back(v);
      default: q3.push_back(v);
    endcase
  endtask

  task automatic sb_pop(input int d, output logic [15:0] v, output bit hit);
    hit = 1'b0;
    v   = 16'h0000;
    case (d)
      0: if (q0.size() > 0) begin v = q0.pop_front(); hit = 1'b1; end
      1: if (q1.size() > 0) begin v = q1.pop_front(); hit = 1'b1; end
      2: if (q2.size() > 0) begin v = q2.pop_front(); hit = 1'b1; end
      default: if (q3.size() > 0) begin v = q3.pop_front(); hit = 1'b1; end
    endcase
  endtask

  // Decodes the line cycle by cycle; checks bit hold, Active, Done timing and data.
  task automatic mon(input int d, input int nb, input int pe, input int ns);
    int          f_len;
    logic        prev;
    logic [15:0] fr;
    logic [15:0] ex;
    bit          hit, hold_ok, abort, more;
    f_len = (1 + nb + pe + ns) * CPB;
    prev  = 1'b1;
    forever begin
      @(negedge clk);
      more = rst_n && prev && !ser[d];
      while (more) begin
        more    = 1'b0;
        abort   = 1'b0;
        hold_ok = 1'b1;
        fr      = 16'h0000;
        for (int j = 0; j < f_len; j++) begin
          if (j > 0) begin
            @(negedge clk);
            if (!rst_n) begin
              abort = 1'b1;
              break;
            end
            if (dne[d]) hold_ok = 1'b0;
          end
          if (j % CPB == 0) fr[j / CPB] = ser[d];
          else if (ser[d] !== fr[j / CPB]) hold_ok = 1'b0;
          if (act[d] !== 1'b1) hold_ok = 1'b0;
        end
        if (!abort) begin
          @(negedge clk);
          check_eq($sformatf("done_timing_d%0d", d), int'(dne[d]), 1);
          check_eq($sformatf("bit_hold_active_d%0d", d), int'(hold_ok), 1);
          sb_pop(d, ex, hit);
          check_eq($sformatf("expected_frame_present_d%0d", d), int'(hit), 1);
          if (hit) check_eq($sformatf("frame_d%0d", d), int'(fr), int'(ex));
          more = rst_n && !ser[d];
        end
      end
      prev = ser[d];
    end
  endtask

  // Tallies Done pulses per instance
  always @(negedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (dne[i]) done_cnt[i]++;
    end
  end

  task automatic meas_active(input int d, output int cnt);
    cnt = 0;
    for (int k = 0; k < 400; k++) begin
      @(negedge clk);
      if (act[d]) cnt++;
      else if (cnt > 0) break;
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    fork
      mon(0, 8, 0, 1);
      mon(1, 8, 1, 1);
      mon(2, 8, 1, 1);
      mon(3, 7, 0, 2);
    join_none
  end

  initial begin
    int  cnt_a, cnt_b, cnt_d, waited;
    bit  all_high;
    ifa.in_Tx_DV = 1'b0; ifa.in_Tx_Byte = 8'h00;
    ifb.in_Tx_DV = 1'b0; ifb.in_Tx_Byte = 8'h00;
    ifc.in_Tx_DV = 1'b0; ifc.in_Tx_Byte = 8'h00;
    ifd.in_Tx_DV = 1'b0; ifd.in_Tx_Byte = 7'h00;

    // Reset state
    repeat (3) @(negedge clk);
    check_eq("rst_serial", int'(ifa.out_Tx_Serial), 1);
    check_eq("rst_active", int'(ifa.out_Tx_Active), 0);
    check_eq("rst_done", int'(ifa.out_Tx_Done), 0);
    check_eq("rst_count", int'(ifa.out_Fifo_Count), 0);
    check_eq("rst_ready", int'(ifa.out_Tx_Ready), 1);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Basic 0xA5 on A, 0x07 even/odd parity on B/C, 7-bit 2-stop 0x55 on D
    sb_push(0, 16'h034A);
    sb_push(1, 16'h060E);
    sb_push(2, 16'h040E);
    sb_push(3, 16'h03AA);
    fork
      meas_active(0, cnt_a);
      meas_active(1, cnt_b);
      meas_active(3, cnt_d);
      begin
        ifa.in_Tx_DV = 1'b1; ifa.in_Tx_Byte = 8'hA5;
        ifb.in_Tx_DV = 1'b1; ifb.in_Tx_Byte = 8'h07;
        ifc.in_Tx_DV = 1'b1; ifc.in_Tx_Byte = 8'h07;
        ifd.in_Tx_DV = 1'b1; ifd.in_Tx_Byte = 7'h55;
        @(negedge clk);
        ifa.in_Tx_DV = 1'b0; ifb.in_Tx_DV = 1'b0; ifc.in_Tx_DV = 1'b0; ifd.in_Tx_DV = 1'b0;
        check_eq("latency_line_still_high", int'(ifa.out_Tx_Serial), 1);
        check_eq("latency_count_one", int'(ifa.out_Fifo_Count), 1);
        @(negedge clk);
        check_eq("latency_start_fall", int'(ifa.out_Tx_Serial), 0);
        check_eq("latency_active_rise", int'(ifa.out_Tx_Active), 1);
        check_eq("latency_count_popped", int'(ifa.out_Fifo_Count), 0);
      end
    join
    check_eq("active_len_8n1", cnt_a, 40);
    check_eq("active_len_parity", cnt_b, 44);
    check_eq("active_len_7n2", cnt_d, 40);
    repeat (10) @(negedge clk);
    check_eq("done_count_a_basic", done_cnt[0], 1);
    check_eq("done_count_c_parity", done_cnt[2], 1);

    // Back-to-back 0x11, 0x22, 0x33
    sb_push(0, 16'h0222);
    sb_push(0, 16'h0244);
    sb_push(0, 16'h0266);
    fork
      meas_active(0, cnt_a);
      begin
        ifa.in_Tx_DV = 1'b1; ifa.in_Tx_Byte = 8'h11;
        @(negedge clk); ifa.in_Tx_Byte = 8'h22;
        @(negedge clk); ifa.in_Tx_Byte = 8'h33;
        @(negedge clk); ifa.in_Tx_DV = 1'b0;
        check_eq("b2b_count", int'(ifa.out_Fifo_Count), 2);
      end
    join
    check_eq("b2b_active_len", cnt_a, 120);
    repeat (3) @(negedge clk);
    check_eq("b2b_done_count", done_cnt[0], 4);

    // Overflow: six writes, the sixth must be dropped
    repeat (5) @(negedge clk);
    for (int i = 0; i < 5; i++) sb_push(0, 16'h0200 | 16'(i << 1));
    for (int i = 0; i < 6; i++) begin
      ifa.in_Tx_DV = 1'b1;
      ifa.in_Tx_Byte = 8'(i);
      @(negedge clk);
      if (i == 3) check_eq("ovf_ready_at3", int'(ifa.out_Tx_Ready), 1);
      if (i == 4) begin
        check_eq("ovf_count_full", int'(ifa.out_Fifo_Count), 4);
        check_eq("ovf_ready_low", int'(ifa.out_Tx_Ready), 0);
      end
      if (i == 5) check_eq("ovf_count_after_drop", int'(ifa.out_Fifo_Count), 4);
    end
    ifa.in_Tx_DV = 1'b0;
    waited = 0;
    while (q0.size() != 0 && waited < 600) begin
      @(negedge clk);
      waited++;
    end
    check_eq("ovf_frames_drained", q0.size(), 0);
    repeat (60) @(negedge clk);
    check_eq("ovf_done_count", done_cnt[0], 9);

    // Reset during data bit 3 of 0x35 (bit 3 is 0)
    ifa.in_Tx_DV = 1'b1; ifa.in_Tx_Byte = 8'h35;
    @(negedge clk);
    ifa.in_Tx_DV = 1'b0;
    @(negedge clk);
    repeat (17) @(negedge clk);
    check_eq("rstmid_in_bit3", int'(ifa.out_Tx_Serial), 0);
    rst_n = 1'b0;
    #1;
    check_eq("rstmid_line_high", int'(ifa.out_Tx_Serial), 1);
    check_eq("rstmid_active_low", int'(ifa.out_Tx_Active), 0);
    check_eq("rstmid_count_zero", int'(ifa.out_Fifo_Count), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    all_high = 1'b1;
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      if (ifa.out_Tx_Serial !== 1'b1 || ifa.out_Tx_Active !== 1'b0) all_high = 1'b0;
    end
    check_eq("rstmid_idle_after_release", int'(all_high), 1);
    check_eq("rstmid_no_done", done_cnt[0], 9);

    check_eq("sb_empty_a", q0.size(), 0);
    check_eq("sb_empty_b", q1.size(), 0);
    check_eq("sb_empty_c", q2.size(), 0);
    check_eq("sb_empty_d", q3.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
